// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: four byte reads from flash assembled into a 32-bit word
module fetch_unit #(
    parameter int                    ADDR_WIDTH   = 24,
    parameter int                    READ_LATENCY = 3,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_en,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  flash_re,
    output logic [ADDR_WIDTH-1:0] flash_addr,
    input  logic [7:0]            flash_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [1:0]              byte_cnt;
    logic [3:0]              wait_cnt;
    logic                    handshake;
    logic                    wait_done;

    assign handshake = (state == HOLD) && instr_valid && instr_ready;
    // counter reaches zero on this edge, i.e. READ_LATENCY edges after launch
    assign wait_done = (state == WAIT) && (wait_cnt == 4'd1);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (fetch_en) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT:  if (wait_done) state_next = (byte_cnt == 2'd3) ? HOLD : ISSUE;
            HOLD:  if (handshake) state_next = fetch_en ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
        if (redirect) begin
            state_next = fetch_en ? ISSUE : IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            byte_cnt    <= 2'd0;
            wait_cnt    <= 4'd0;
            instr       <= 32'd0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            flash_re    <= 1'b0;
            flash_addr  <= '0;
        end else if (redirect) begin
            // a same-cycle handshake still retires the word; only the next pc changes
            pc          <= redirect_addr;
            byte_cnt    <= 2'd0;
            flash_re    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                ISSUE: begin
                    flash_re   <= 1'b1;
                    flash_addr <= pc + ADDR_WIDTH'(byte_cnt);
                    wait_cnt   <= 4'(READ_LATENCY);
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_done) begin
                        instr[{byte_cnt, 3'b000} +: 8] <= flash_data;
                        if (byte_cnt == 2'd3) begin
                            flash_re    <= 1'b0;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        instr_valid <= 1'b0;
                        pc          <= pc + ADDR_WIDTH'(4);
                        byte_cnt    <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
